// File: rtl/hazard_scoreboard.sv
// rtl/hazard_scoreboard.sv - issue-side register hazard scoreboard with load-use tracker
module hazard_scoreboard #(
    parameter int NUM_REGS = 16,
    parameter int REG_W    = 4,
    parameter int CNT_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                flush,
    input  logic                fwd_en,
    input  logic                id_valid,
    input  logic                id_use_src1,
    input  logic                id_two_src,
    input  logic [REG_W-1:0]    id_src1,
    input  logic [REG_W-1:0]    id_src2,
    input  logic                id_wb_en,
    input  logic [REG_W-1:0]    id_dest,
    input  logic                id_mem_r,
    input  logic                wb_wb_en,
    input  logic [REG_W-1:0]    wb_dest,
    output logic                hazard,
    output logic [NUM_REGS-1:0] pending,
    output logic                sb_err
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Per-register in-flight write counters
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
    logic [NUM_REGS-1:0][CNT_W-1:0] cnt_next;
    logic [NUM_REGS-1:0]            pend_next;
    logic [NUM_REGS-1:0]            eff;
    logic [NUM_REGS-1:0]            inc;
    logic [NUM_REGS-1:0]            dec;
    logic [NUM_REGS-1:0]            ovf;
    logic [NUM_REGS-1:0]            unf;

    // One-deep tracker of the load currently in EXE
    logic             exe_ld_v;
    logic [REG_W-1:0] exe_ld_dest;

    logic retire;
    logic issue;
    logic wr;
    logic src1_hit;
    logic src2_hit;

    assign retire = wb_wb_en & ~freeze;
    assign issue  = id_valid & ~hazard & ~freeze & ~flush;
    assign wr     = issue & id_wb_en;

    // Effective pending: a last outstanding write retiring this cycle is already
    // visible in the register file because it writes before it reads
    always_comb begin
        eff = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            eff[i] = (cnt[i] != '0) &&
                     !((cnt[i] == CNT_ONE) && retire && (wb_dest == REG_W'(i)));
        end
    end

    // Stall request: any pending write without forwarding, only load-use with it
    always_comb begin
        src1_hit = 1'b0;
        src2_hit = 1'b0;
        if (fwd_en) begin
            src1_hit = id_use_src1 && (id_src1 == exe_ld_dest);
            src2_hit = id_two_src  && (id_src2 == exe_ld_dest);
            hazard   = id_valid && exe_ld_v && (src1_hit || src2_hit);
        end else begin
            src1_hit = id_use_src1 && eff[id_src1];
            src2_hit = id_two_src  && eff[id_src2];
            hazard   = id_valid && (src1_hit || src2_hit);
        end
    end

    // Next-state counters with saturation and error detection
    always_comb begin
        cnt_next  = cnt;
        inc       = '0;
        dec       = '0;
        ovf       = '0;
        unf       = '0;
        pend_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = wr     && (id_dest == REG_W'(i));
            dec[i] = retire && (wb_dest == REG_W'(i));
            if (inc[i] && !dec[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    ovf[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] + CNT_ONE;
                end
            end else if (dec[i] && !inc[i]) begin
                if (cnt[i] == '0) begin
                    unf[i] = 1'b1;
                end else begin
                    cnt_next[i] = cnt[i] - CNT_ONE;
                end
            end
            pend_next[i] = (cnt_next[i] != '0);
        end
    end

    // Counter, pending mask and sticky error registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            cnt     <= cnt_next;
            pending <= pend_next;
            if ((|ovf) || (|unf)) begin
                sb_err <= 1'b1;
            end
        end
    end

    // Load tracker: holds while frozen, otherwise a stall or flush becomes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exe_ld_v    <= 1'b0;
            exe_ld_dest <= '0;
        end else if (!freeze) begin
            exe_ld_v    <= issue & id_wb_en & id_mem_r;
            exe_ld_dest <= id_dest;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb/tb_hazard_scoreboard.sv - directed vector bench for hazard_scoreboard
module tb_hazard_scoreboard;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        fwd_en;
    logic        id_valid;
    logic        id_use_src1;
    logic        id_two_src;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic        id_mem_r;
    logic        wb_wb_en;
    logic [3:0]  wb_dest;
    logic        hazard;
    logic [15:0] pending;
    logic        sb_err;

    int checks;
    int errors;

    typedef struct {
        logic        fz;
        logic        fl;
        logic        fwd;
        logic        idv;
        logic        u1;
        logic        two;
        logic [3:0]  s1;
        logic [3:0]  s2;
        logic        wbe;
        logic [3:0]  dst;
        logic        mr;
        logic        wbwe;
        logic [3:0]  wbd;
        logic        exp_h;
        logic [15:0] exp_pend;
        logic        exp_err;
        string       name;
    } vec_t;

    vec_t vecs[$];

    hazard_scoreboard dut (
        .clk         (clk),
        .rst         (rst),
        .freeze      (freeze),
        .flush       (flush),
        .fwd_en      (fwd_en),
        .id_valid    (id_valid),
        .id_use_src1 (id_use_src1),
        .id_two_src  (id_two_src),
        .id_src1     (id_src1),
        .id_src2     (id_src2),
        .id_wb_en    (id_wb_en),
        .id_dest     (id_dest),
        .id_mem_r    (id_mem_r),
        .wb_wb_en    (wb_wb_en),
        .wb_dest     (wb_dest),
        .hazard      (hazard),
        .pending     (pending),
        .sb_err      (sb_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(int fz, int fl, int fwd, int idv, int u1, int two,
                                int s1, int s2, int wbe, int dst, int mr, int wbwe,
                                int wbd, int h, int pend, int err, string name);
        vec_t v;
        v.fz = fz[0]; v.fl = fl[0]; v.fwd = fwd[0]; v.idv = idv[0];
        v.u1 = u1[0]; v.two = two[0]; v.s1 = s1[3:0]; v.s2 = s2[3:0];
        v.wbe = wbe[0]; v.dst = dst[3:0]; v.mr = mr[0];
        v.wbwe = wbwe[0]; v.wbd = wbd[3:0];
        v.exp_h = h[0]; v.exp_pend = pend[15:0]; v.exp_err = err[0];
        v.name = name;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        freeze = 0; flush = 0; id_valid = 0; id_use_src1 = 0; id_two_src = 0;
        id_src1 = 0; id_src2 = 0; id_wb_en = 0; id_dest = 0; id_mem_r = 0;
        wb_wb_en = 0; wb_dest = 0;
    endtask

    // Drive at negedge, check hazard mid-cycle, check registers after the edge
    task automatic apply(input vec_t v);
        @(negedge clk);
        freeze = v.fz; flush = v.fl; fwd_en = v.fwd; id_valid = v.idv;
        id_use_src1 = v.u1; id_two_src = v.two; id_src1 = v.s1; id_src2 = v.s2;
        id_wb_en = v.wbe; id_dest = v.dst; id_mem_r = v.mr;
        wb_wb_en = v.wbwe; wb_dest = v.wbd;
        #1;
        chk({v.name, ".hazard"}, 32'(hazard), 32'(v.exp_h));
        @(posedge clk);
        #1;
        chk({v.name, ".pending"}, 32'(pending), 32'(v.exp_pend));
        chk({v.name, ".sb_err"}, 32'(sb_err), 32'(v.exp_err));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        idle_inputs();
        #1;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1;
        fwd_en = 0;
        idle_inputs();
        #12;
        chk("reset.hazard", 32'(hazard), 32'd0);
        chk("reset.pending", 32'(pending), 32'd0);
        chk("reset.sb_err", 32'(sb_err), 32'd0);
        @(negedge clk);
        rst = 0;

        //        fz fl fw iv u1 tw s1 s2 we ds mr ww wd  h  pend    err
        // Non-forwarding RAW stall until WB
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 'h0002, 0, "t1_add_r1"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 8, 0, 0, 0, 1, 'h0002, 0, "t1_stall_a"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 8, 0, 0, 0, 1, 'h0002, 0, "t1_stall_b"));
        vecs.push_back(mk(0, 0, 0, 1, 1, 0, 1, 0, 1, 8, 0, 1, 1, 0, 'h0100, 0, "t1_wb_issue"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 'h0000, 0, "t1_ret_r8"));
        // Forwarding: load-use stalls once, ALU producer never stalls
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 2, 1, 0, 0, 0, 'h0004, 0, "t2_ldr_r2"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 1, 'h0004, 0, "t2_ld_use"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 2, 0, 0, 0, 0, 0, 0, 'h0004, 0, "t2_ld_go"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 'h0204, 0, "t2_add_r9"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 1, 0, 9, 0, 0, 0, 0, 0, 0, 'h0204, 0, "t2_alu_use"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 'h0200, 0, "t2_ret_r2"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 'h0000, 0, "t2_ret_r9"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 10, 1, 0, 0, 0, 'h0400, 0, "t2_ldr_r10"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 10, 3, 0, 0, 0, 0, 0, 1, 'h0400, 0, "t2_src1_use"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 1, 10, 3, 0, 0, 0, 0, 0, 0, 'h0400, 0, "t2_src1_go"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 'h0000, 0, "t2_ret_r10"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 11, 1, 0, 0, 0, 'h0800, 0, "t2_ldr_r11"));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 11, 0, 0, 0, 0, 0, 0, 0, 'h0800, 0, "t2_unused_src"));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 11, 0, 'h0000, 0, "t2_ret_r11"));
        // Counter saturation and same-cycle issue/retire
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 'h0008, 0, "t3_wr3_a"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 'h0008, 0, "t3_wr3_b"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 'h0008, 0, "t3_wr3_c"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 'h0008, 1, "t3_overflow"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 'h0008, 1, "t3_ret3_a"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 'h0008, 1, "t3_ret3_b"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 'h0000, 1, "t3_ret3_c"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 'h0010, 1, "t3_wr4"));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 4, 0, 1, 4, 0, 'h0010, 1, "t3_wr_ret4"));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 'h0000, 1, "t3_ret4"));
        // Flush discards the ID instruction and bubbles the load tracker
        vecs.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 0, 'h0000, 1, "t5_flush_wr6"));
        vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 1, 12, 1, 0, 0, 0, 'h0000, 1, "t5_flush_ld"));
        vecs.push_back(mk(0, 0, 1, 1, 1, 0, 12, 0, 0, 0, 0, 0, 0, 0, 'h0000, 1, "t5_no_ld_use"));

        foreach (vecs[k]) apply(vecs[k]);

        // Freeze holds counters and the load tracker; release then retires
        do_reset();
        apply(mk(0, 0, 1, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0, 'h0020, 0, "t4_ldr_r5"));
        for (int c = 0; c < 4; c++) begin
            apply(mk(1, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 1, 5, 1, 'h0020, 0, "t4_frozen"));
        end
        apply(mk(0, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 1, 5, 1, 'h0000, 0, "t4_release"));
        apply(mk(0, 0, 1, 1, 1, 0, 5, 0, 0, 0, 0, 0, 0, 0, 'h0000, 0, "t4_use_go"));

        // Asynchronous reset mid-cycle, then a stale retire underflows
        do_reset();
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 'h0080, 0, "t6_wr7_a"));
        apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 'h0080, 0, "t6_wr7_b"));
        @(posedge clk);
        idle_inputs();
        #2;
        rst = 1;
        #1;
        chk("t6_async.pending", 32'(pending), 32'd0);
        chk("t6_async.sb_err", 32'(sb_err), 32'd0);
        #1;
        rst = 0;
        apply(mk(0, 0, 0, 1, 1, 0, 7, 0, 0, 0, 0, 1, 7, 0, 'h0000, 1, "t6_stale_ret"));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
